vec_result_collector: RTL and testbench
=======================================

// Module: vec_result_collector
// PURPOSE
//  Downstream of the vec_alu lanes. Gathers the per-cycle result chunks
//  (vd, reg_index) produced by up to 4 lanes into one VLEN-bit destination
//  register image, then presents it once, with a valid/ready handshake, to the
//  vector register file write port.
//  Replaces the bench-side vd[regi +: w] assembly with synthesizable RTL.
// PARAMETERS
//  VLEN        128  vector register length in bits (multiple of 64, <= 512)
//  LANE_WIDTH  3    log2 of lane datapath width in bits (3..6 -> 8..64 b)
//  MAX_LANES   4    number of lane input ports instantiated (1, 2 or 4)
// PORTS
//  clk             in   1          system clock, rising edge
//  reset           in   1          asynchronous, active-high reset
//  start           in   1          pulse: begin collecting one register
//  start_vsew      in   3          element width code (0:8b .. 3:64b)
//  start_nb_lanes  in   2          log2 of active lanes (0:1, 1:2, 2:4)
//  start_vd_addr   in   5          destination vector register number
//  busy            out  1          high in COLLECT or WRITE
//  lane_valid      in   MAX_LANES  lane i chunk valid this cycle
//  lane_vd         in   64*MAX_LANES  lane i result, chunk in bits [W-1:0]
//  lane_idx        in   10*MAX_LANES  lane i bit offset into destination
//  wb_valid        out  1          destination image ready for write
//  wb_ready        in   1          register file accepts the write
//  wb_addr         out  5          latched start_vd_addr
//  wb_data         out  VLEN       assembled destination register
//  err             out  1          sticky protocol-error flag
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, wb_valid=0, wb_addr=0, wb_data=0, err=0,
//   chunk counter=0. Reset mid-operation aborts and drops partial data.
//  Chunk width W = min(8<<vsew, 1<<LANE_WIDTH). Expected chunks N = VLEN/W.
//  FSM IDLE -> COLLECT -> WRITE -> IDLE.
//  IDLE: on start, latch vsew/nb_lanes/vd_addr, clear accumulator and
//   counter, go COLLECT (busy=1 next cycle). start_vsew>3 -> stay IDLE, set err.
//  COLLECT: each cycle, for each lane i < (1<<nb_lanes) with lane_valid[i]:
//   acc[lane_idx_i +: W] <= lane_vd_i[W-1:0]; counter += number accepted.
//   Visible in wb_data... only after WRITE (acc internal until then).
//   Lanes >= (1<<nb_lanes) ignored silently.
//   Chunk with lane_idx+W > VLEN or lane_idx not a multiple of W: dropped,
//   not counted, err set.
//   Two lanes writing the same offset in one cycle: higher lane index wins,
//   both counted, err set.
//   When counter+accepted >= N on a clock edge: go WRITE; wb_valid=1 next
//   cycle (1 cycle after last chunk). Overshoot (>N) sets err.
//  WRITE: wb_valid=1, wb_data/wb_addr held stable until wb_valid&&wb_ready;
//   then IDLE, wb_valid=0 and busy=0 next cycle. lane_valid ignored (err if
//   seen). start in COLLECT or WRITE ignored, err set.
//  start in the same cycle as the wb handshake: ignored (IDLE not yet reached).
//  err clears only on reset.
// TESTING
//  1) VLEN=128, LANE_WIDTH=3, 1 lane, vsew=0, vadd.vv chunks from vec_alu,
//     vs1=abcdabcdbeefbeef1234567887654321, vs2=8765432112345678beefbeefabcdabcd
//     -> 16 chunks, wb_valid 1 cycle after last,
//     wb_data=3232eeeed0231467d02314673232eeee.
//  2) Same operands, vsew=3, LANE_WIDTH=3 (W=8) -> 16 chunks,
//     wb_data=3332eeeed1241567d12415683332eeee.
//  3) 4 lanes, LANE_WIDTH=5, vsew=2, idx 0/32/64/96 in one cycle -> WRITE
//     after 1 cycle, wb_addr=start_vd_addr.
//  4) Hold wb_ready=0 for 5 cycles -> wb_valid and wb_data stable;
//     wb_ready=1 -> busy=0 next cycle.
//  5) lane_idx=124, W=8 -> chunk dropped, err=1, counter unchanged.
//  6) Assert reset at chunk 7 of 16 -> all outputs 0; a new start collects
//     cleanly.

Source files
------------

// File: rtl/vec_result_collector_if.sv
// Bundle between the vec_alu lane side / register-file write port and the result collector.
// Handshake: the write to the register file happens on a clock edge where wb_valid && wb_ready;
// while wb_valid is high and wb_ready low, wb_addr and wb_data stay stable. lane_valid qualifies a chunk for one cycle.
interface vec_result_collector_if #(
    parameter int VLEN      = 128,
    parameter int MAX_LANES = 4
);
    logic                      start;
    logic [2:0]                start_vsew;
    logic [1:0]                start_nb_lanes;
    logic [4:0]                start_vd_addr;
    logic                      busy;
    logic [MAX_LANES-1:0]      lane_valid;
    logic [64*MAX_LANES-1:0]   lane_vd;
    logic [10*MAX_LANES-1:0]   lane_idx;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [4:0]                wb_addr;
    logic [VLEN-1:0]           wb_data;
    logic                      err;

    modport slave (
        input  start, start_vsew, start_nb_lanes, start_vd_addr,
        input  lane_valid, lane_vd, lane_idx, wb_ready,
        output busy, wb_valid, wb_addr, wb_data, err
    );

    modport master (
        output start, start_vsew, start_nb_lanes, start_vd_addr,
        output lane_valid, lane_vd, lane_idx, wb_ready,
        input  busy, wb_valid, wb_addr, wb_data, err
    );
endinterface

// File: rtl/vec_result_collector.sv
// Assembles per-lane result chunks into one VLEN-bit destination register image and
// hands it to the register file write port through a valid/ready handshake.
module vec_result_collector #(
    parameter  int VLEN       = 128,
    parameter  int LANE_WIDTH = 3,
    parameter  int MAX_LANES  = 4,
    localparam int CW         = $clog2(VLEN/8) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    vec_result_collector_if.slave bus,
    output logic [1:0]            dbg_state_o,
    output logic [CW-1:0]         dbg_count_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      vsew_q, vsew_d;
    logic [1:0]      nb_q, nb_d;
    logic [4:0]      addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VLEN-1:0] acc_q, acc_d;
    logic            err_q, err_d;

    logic [3:0]      w_log;
    logic [10:0]     w_bits;
    logic [CW-1:0]   n_chunks;
    logic [VLEN-1:0] w_mask;

    logic [9:0]           off;
    logic [MAX_LANES-1:0] lane_ok;
    logic [9:0]           lane_off [MAX_LANES];
    logic [2:0]           accepted;
    logic [CW-1:0]        sum;
    logic [VLEN-1:0]      chunk;

    // Chunk width is the element width capped by the lane datapath width.
    assign w_log    = (4'd3 + {1'b0, vsew_q} > 4'(LANE_WIDTH)) ? 4'(LANE_WIDTH)
                                                               : 4'd3 + {1'b0, vsew_q};
    assign w_bits   = 11'd1 << w_log;
    assign n_chunks = CW'(VLEN >> w_log);
    assign w_mask   = (VLEN'(1) << w_bits) - VLEN'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vsew_q  <= '0;
            nb_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsew_q  <= vsew_d;
            nb_q    <= nb_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vsew_d   = vsew_q;
        nb_d     = nb_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        err_d    = err_q;
        off      = '0;
        lane_ok  = '0;
        accepted = '0;
        sum      = cnt_q;
        chunk    = '0;
        for (int i = 0; i < MAX_LANES; i++) lane_off[i] = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.start_vsew > 3'd3) begin
                        err_d = 1'b1;
                    end else begin
                        vsew_d  = bus.start_vsew;
                        nb_d    = bus.start_nb_lanes;
                        addr_d  = bus.start_vd_addr;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (bus.start) err_d = 1'b1;
                // Lanes are walked in ascending order so a higher lane overwrites a lower one.
                for (int i = 0; i < MAX_LANES; i++) begin
                    off         = bus.lane_idx[i*10 +: 10];
                    lane_off[i] = off;
                    if (bus.lane_valid[i] && (i < (1 << nb_q))) begin
                        if (({1'b0, off} + w_bits > 11'(VLEN)) ||
                            ((off & (w_bits[9:0] - 10'd1)) != 10'd0)) begin
                            err_d = 1'b1;
                        end else begin
                            for (int j = 0; j < i; j++) begin
                                if (lane_ok[j] && (lane_off[j] == off)) err_d = 1'b1;
                            end
                            lane_ok[i] = 1'b1;
                            accepted   = accepted + 3'd1;
                            chunk      = VLEN'(bus.lane_vd[i*64 +: 64]) & w_mask;
                            acc_d      = (acc_d & ~(w_mask << off)) | (chunk << off);
                        end
                    end
                end
                sum   = cnt_q + CW'(accepted);
                cnt_d = sum;
                if (sum >= n_chunks) begin
                    state_d = S_WRITE;
                    if (sum > n_chunks) err_d = 1'b1;
                end
            end

            S_WRITE: begin
                if (bus.start) err_d = 1'b1;
                if (|bus.lane_valid) err_d = 1'b1;
                if (bus.wb_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.wb_valid = (state_q == S_WRITE);
    assign bus.wb_addr  = addr_q;
    assign bus.wb_data  = (state_q == S_WRITE) ? acc_q : '0;
    assign bus.err      = err_q;

    assign dbg_state_o  = state_q;
    assign dbg_count_o  = cnt_q;

endmodule

// File: tb/tb_vec_result_collector.sv
// Bench for vec_result_collector: a table of full-register collections on an 8-bit-lane
// instance, plus hand sequences on a 32-bit-lane instance for the multi-cycle corner cases.
module tb_vec_result_collector;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vec_result_collector_if #(.VLEN(128), .MAX_LANES(4)) ifa ();
    vec_result_collector_if #(.VLEN(128), .MAX_LANES(4)) ifb ();

    logic [1:0] dbg_state_a, dbg_state_b;
    logic [5:0] dbg_cnt_a, dbg_cnt_b;

    vec_result_collector #(.VLEN(128), .LANE_WIDTH(3), .MAX_LANES(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .dbg_state_o(dbg_state_a), .dbg_count_o(dbg_cnt_a)
    );

    vec_result_collector #(.VLEN(128), .LANE_WIDTH(5), .MAX_LANES(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .dbg_state_o(dbg_state_b), .dbg_count_o(dbg_cnt_b)
    );

    typedef struct {
        logic [2:0]   vsew;
        logic [1:0]   nb;
        logic [4:0]   addr;
        logic [127:0] vs1;
        logic [127:0] vs2;
        logic [127:0] exp;
    } vec_t;

    vec_t         tbl [4];
    logic [127:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Element-wise wrap-around add, element width 8<<vsew.
    function automatic logic [127:0] vadd(input logic [127:0] a, input logic [127:0] b,
                                          input logic [2:0] vsew);
        int ew;
        logic [127:0] r;
        logic [63:0] x, y, s;
        ew = 8 << vsew;
        r  = '0;
        for (int e = 0; e < 128 / ew; e++) begin
            x = 64'(a >> (e * ew));
            y = 64'(b >> (e * ew));
            s = x + y;
            for (int k = 0; k < ew; k++) r[e*ew + k] = s[k];
        end
        return r;
    endfunction

    task automatic start_a(input logic [2:0] vsew, input logic [1:0] nb, input logic [4:0] addr);
        ifa.start = 1'b1; ifa.start_vsew = vsew; ifa.start_nb_lanes = nb; ifa.start_vd_addr = addr;
        @(posedge clk); #1;
        ifa.start = 1'b0;
    endtask

    task automatic start_b(input logic [2:0] vsew, input logic [1:0] nb, input logic [4:0] addr);
        ifb.start = 1'b1; ifb.start_vsew = vsew; ifb.start_nb_lanes = nb; ifb.start_vd_addr = addr;
        @(posedge clk); #1;
        ifb.start = 1'b0;
    endtask

    task automatic finish_wb_a(input logic [4:0] addr);
        logic [127:0] exp;
        ifa.wb_ready = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        ifa.wb_ready = 1'b1;
        exp = exp_q.pop_front();
        check("a_wb_valid_hs", ifa.wb_valid, 1);
        check("a_wb_data", ifa.wb_data, exp);
        check("a_wb_addr", ifa.wb_addr, addr);
        @(posedge clk); #1;
        ifa.wb_ready = 1'b0;
        check("a_busy_after_wb", ifa.busy, 0);
        check("a_wb_valid_after_wb", ifa.wb_valid, 0);
    endtask

    task automatic finish_wb_b(input logic [4:0] addr);
        logic [127:0] exp;
        ifb.wb_ready = 1'b1;
        exp = exp_q.pop_front();
        check("b_wb_valid_hs", ifb.wb_valid, 1);
        check("b_wb_data", ifb.wb_data, exp);
        check("b_wb_addr", ifb.wb_addr, addr);
        @(posedge clk); #1;
        ifb.wb_ready = 1'b0;
        check("b_busy_after_wb", ifb.busy, 0);
    endtask

    task automatic run_vec(input int r);
        logic [127:0] res;
        int next, cyc, nl;
        bit early;
        res = vadd(tbl[r].vs1, tbl[r].vs2, tbl[r].vsew);
        exp_q.push_back(tbl[r].exp);
        start_a(tbl[r].vsew, tbl[r].nb, tbl[r].addr);
        check("a_busy_on_start", ifa.busy, 1);
        nl = 1 << tbl[r].nb;
        next = 0; cyc = 0; early = 0;
        while (next < 16 && cyc < 200) begin
            ifa.lane_valid = '0;
            for (int l = 0; l < nl; l++) begin
                if (next < 16 && $urandom_range(0, 3) != 0) begin
                    ifa.lane_valid[l]        = 1'b1;
                    ifa.lane_idx[l*10 +: 10] = 10'(next * 8);
                    ifa.lane_vd[l*64 +: 64]  = {$urandom(), 24'($urandom()), res[next*8 +: 8]};
                    next++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (next < 16 && ifa.wb_valid) early = 1'b1;
        end
        ifa.lane_valid = '0;
        if (cyc >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL a_feed_timeout: row %0d stalled after %0d chunks", r, next);
        end
        check("a_no_early_wb", early, 0);
        check("a_wb_valid_after_last", ifa.wb_valid, 1);
        finish_wb_a(tbl[r].addr);
        check("a_err_clean", ifa.err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d [4];
        logic [127:0] exp;

        tbl[0] = '{3'd0, 2'd0, 5'd3, 128'habcdabcdbeefbeef1234567887654321,
                   128'h8765432112345678beefbeefabcdabcd, 128'h3232eeeed0231467d02314673232eeee};
        tbl[1] = '{3'd3, 2'd0, 5'd7, 128'habcdabcdbeefbeef1234567887654321,
                   128'h8765432112345678beefbeefabcdabcd, 128'h3332eeeed1241567d12415683332eeee};
        for (int r = 2; r < 4; r++) begin
            tbl[r].vsew = 3'(r - 1);
            tbl[r].nb   = 2'(r - 1);
            tbl[r].addr = 5'(10 + 9 * r);
            tbl[r].vs1  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[r].vs2  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[r].exp  = vadd(tbl[r].vs1, tbl[r].vs2, tbl[r].vsew);
        end

        ifa.start = 0; ifa.start_vsew = 0; ifa.start_nb_lanes = 0; ifa.start_vd_addr = 0;
        ifa.lane_valid = '0; ifa.lane_vd = '0; ifa.lane_idx = '0; ifa.wb_ready = 0;
        ifb.start = 0; ifb.start_vsew = 0; ifb.start_nb_lanes = 0; ifb.start_vd_addr = 0;
        ifb.lane_valid = '0; ifb.lane_vd = '0; ifb.lane_idx = '0; ifb.wb_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", ifa.busy, 0);
        check("rst_wb_valid", ifa.wb_valid, 0);
        check("rst_wb_addr", ifa.wb_addr, 0);
        check("rst_wb_data", ifa.wb_data, 0);
        check("rst_err", ifa.err, 0);
        check("rst_state", dbg_state_a, 0);
        check("rst_count", dbg_cnt_a, 0);
        check("rst_b_busy", ifb.busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 4; r++) run_vec(r);

        // Four 32-bit chunks in one cycle, then a stalled write port.
        for (int l = 0; l < 4; l++) d[l] = $urandom();
        exp_q.push_back({d[3], d[2], d[1], d[0]});
        start_b(3'd2, 2'd2, 5'd21);
        ifb.lane_valid = 4'hf;
        for (int l = 0; l < 4; l++) begin
            ifb.lane_idx[l*10 +: 10] = 10'(32 * l);
            ifb.lane_vd[l*64 +: 64]  = {$urandom(), d[l]};
        end
        @(posedge clk); #1;
        ifb.lane_valid = '0;
        check("b_wb_valid_1cyc", ifb.wb_valid, 1);
        check("b_wb_addr_latched", ifb.wb_addr, 21);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("b_hold_valid", ifb.wb_valid, 1);
            check("b_hold_data", ifb.wb_data, exp_q[0]);
        end
        finish_wb_b(5'd21);
        check("b_err_clean", ifb.err, 0);

        // Two lanes on the same offset: higher lane wins, both counted.
        for (int l = 0; l < 4; l++) d[l] = $urandom();
        exp_q.push_back({d[3], d[2], 32'h0, d[1]});
        start_b(3'd2, 2'd2, 5'd5);
        ifb.lane_valid = 4'hf;
        ifb.lane_idx   = {10'd96, 10'd64, 10'd0, 10'd0};
        for (int l = 0; l < 4; l++) ifb.lane_vd[l*64 +: 64] = {32'h0, d[l]};
        @(posedge clk); #1;
        ifb.lane_valid = '0;
        check("b_dup_err", ifb.err, 1);
        check("b_dup_count", dbg_cnt_b, 4);
        finish_wb_b(5'd5);

        // Out-of-range / misaligned chunk is dropped and flagged.
        start_a(3'd0, 2'd0, 5'd9);
        for (int c = 0; c < 3; c++) begin
            ifa.lane_valid = 4'h1; ifa.lane_idx[9:0] = 10'(c * 8); ifa.lane_vd[63:0] = 64'($urandom());
            @(posedge clk); #1;
        end
        check("a_count_3", dbg_cnt_a, 3);
        check("a_err_before_bad", ifa.err, 0);
        ifa.lane_idx[9:0] = 10'd124;
        @(posedge clk); #1;
        check("a_bad_idx_err", ifa.err, 1);
        check("a_bad_idx_count", dbg_cnt_a, 3);
        for (int c = 3; c < 7; c++) begin
            ifa.lane_valid = 4'h1; ifa.lane_idx[9:0] = 10'(c * 8); ifa.lane_vd[63:0] = 64'($urandom());
            @(posedge clk); #1;
        end
        ifa.lane_valid = '0;
        check("a_count_7", dbg_cnt_a, 7);
        check("a_busy_mid", ifa.busy, 1);

        // Asynchronous reset mid-collection drops partial data.
        reset = 1'b1;
        #2;
        check("mid_rst_busy", ifa.busy, 0);
        check("mid_rst_wb_valid", ifa.wb_valid, 0);
        check("mid_rst_wb_addr", ifa.wb_addr, 0);
        check("mid_rst_wb_data", ifa.wb_data, 0);
        check("mid_rst_err", ifa.err, 0);
        check("mid_rst_count", dbg_cnt_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_vec(0);

        // Unsupported element width is refused in IDLE.
        start_a(3'd5, 2'd0, 5'd1);
        check("bad_vsew_busy", ifa.busy, 0);
        check("bad_vsew_state", dbg_state_a, 0);
        check("bad_vsew_err", ifa.err, 1);

        check("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
